pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
//
// The controller chooses the pipeline control action for the current cycle
// using a fixed priority:
//   1. FREEZE - data memory is busy
//   2. FLUSH  - a taken branch or jump resolved in EX
//   3. STALL  - load-use hazard
//   4. NORMAL
// It also tracks the last action as a registered state, keeps saturating
// performance counters, and raises a sticky flag when the memory stays
// busy for too long.
//
// Ports
//   clk_I              : clock; all state updates on its rising edge
//   reset_I            : asynchronous reset, active low
//   ID_rs1Addr_I       : rs1 address of the instruction in ID
//   ID_rs2Addr_I       : rs2 address of the instruction in ID
//   ID_usesRs1_I       : the ID instruction reads rs1
//   ID_usesRs2_I       : the ID instruction reads rs2
//   EX_rdAddr_I        : destination register held in ID/EX
//   EX_memReadEnable_I : the instruction in EX is a load
//   EX_branchTaken_I   : a branch or jump resolved taken in EX
//   memBusy_I          : data memory not ready; freeze the pipeline
//   counterClear_I     : synchronous clear of both performance counters
//   pcWriteEn_O        : PC update enable
//   IF_ID_enable_O     : IF/ID register enable
//   IF_ID_flush_O      : load a NOP into IF/ID
//   ID_EX_enable_O     : ID/EX register enable
//   ID_EX_bubble_O     : zero the ID/EX control inputs
//   state_O            : registered controller state
//   stallCount_O       : stall + freeze cycle count, saturating
//   flushCount_O       : flush cycle count, saturating
//   memTimeout_O       : sticky memory-timeout flag
module pipeline_hazard_controller (
  input  logic        clk_I,
  input  logic        reset_I,
  input  logic [4:0]  ID_rs1Addr_I,
  input  logic [4:0]  ID_rs2Addr_I,
  input  logic        ID_usesRs1_I,
  input  logic        ID_usesRs2_I,
  input  logic [4:0]  EX_rdAddr_I,
  input  logic        EX_memReadEnable_I,
  input  logic        EX_branchTaken_I,
  input  logic        memBusy_I,
  input  logic        counterClear_I,
  output logic        pcWriteEn_O,
  output logic        IF_ID_enable_O,
  output logic        IF_ID_flush_O,
  output logic        ID_EX_enable_O,
  output logic        ID_EX_bubble_O,
  output logic [1:0]  state_O,
  output logic [15:0] stallCount_O,
  output logic [15:0] flushCount_O,
  output logic        memTimeout_O
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        load_use;
  logic        stall_cycle;
  logic        flush_cycle;
  logic [7:0]  busy_run;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = EX_memReadEnable_I && (EX_rdAddr_I != 5'd0) &&
                    ((ID_usesRs1_I && (ID_rs1Addr_I == EX_rdAddr_I)) ||
                     (ID_usesRs2_I && (ID_rs2Addr_I == EX_rdAddr_I)));

  always_comb begin
    state_d        = RUN;
    pcWriteEn_O    = 1'b1;
    IF_ID_enable_O = 1'b1;
    IF_ID_flush_O  = 1'b0;
    ID_EX_enable_O = 1'b1;
    ID_EX_bubble_O = 1'b0;

    if (memBusy_I) begin
      state_d        = MEM_WAIT;
      pcWriteEn_O    = 1'b0;
      IF_ID_enable_O = 1'b0;
      ID_EX_enable_O = 1'b0;
    end else if (EX_branchTaken_I) begin
      // A pending load-use stall is dropped: the ID instruction is squashed.
      state_d        = FLUSH;
      IF_ID_flush_O  = 1'b1;
      ID_EX_bubble_O = 1'b1;
    end else if (load_use) begin
      state_d        = LOAD_STALL;
      pcWriteEn_O    = 1'b0;
      IF_ID_enable_O = 1'b0;
      ID_EX_bubble_O = 1'b1;
    end

    // Hold the pipeline completely idle while in reset.
    if (!reset_I) begin
      pcWriteEn_O    = 1'b0;
      IF_ID_enable_O = 1'b0;
      IF_ID_flush_O  = 1'b0;
      ID_EX_enable_O = 1'b0;
      ID_EX_bubble_O = 1'b0;
    end
  end

  assign stall_cycle = (state_d == MEM_WAIT) || (state_d == LOAD_STALL);
  assign flush_cycle = (state_d == FLUSH);
  assign state_O     = state_q;

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      stallCount_O <= '0;
      flushCount_O <= '0;
    end else if (counterClear_I) begin
      stallCount_O <= '0;
      flushCount_O <= '0;
    end else begin
      if (stall_cycle && (stallCount_O != '1)) begin
        stallCount_O <= stallCount_O + 16'd1;
      end
      if (flush_cycle && (flushCount_O != '1)) begin
        flushCount_O <= flushCount_O + 16'd1;
      end
    end
  end

  // busy_run counts consecutive busy cycles; the timeout fires on the busy
  // cycle that finds it already saturated, and is only cleared by reset.
  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      busy_run     <= '0;
      memTimeout_O <= 1'b0;
    end else begin
      if (!memBusy_I) begin
        busy_run <= '0;
      end else if (busy_run != '1) begin
        busy_run <= busy_run + 8'd1;
      end
      if (memBusy_I && (busy_run == '1)) begin
        memTimeout_O <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios and
// randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

  logic        clk_I = 1'b0;
  logic        reset_I;
  logic [4:0]  ID_rs1Addr_I, ID_rs2Addr_I, EX_rdAddr_I;
  logic        ID_usesRs1_I, ID_usesRs2_I;
  logic        EX_memReadEnable_I, EX_branchTaken_I, memBusy_I, counterClear_I;
  logic        pcWriteEn_O, IF_ID_enable_O, IF_ID_flush_O;
  logic        ID_EX_enable_O, ID_EX_bubble_O, memTimeout_O;
  logic [1:0]  state_O;
  logic [15:0] stallCount_O, flushCount_O;

  always #5 clk_I = ~clk_I;

  pipeline_hazard_controller dut (
    .clk_I              (clk_I),
    .reset_I            (reset_I),
    .ID_rs1Addr_I       (ID_rs1Addr_I),
    .ID_rs2Addr_I       (ID_rs2Addr_I),
    .ID_usesRs1_I       (ID_usesRs1_I),
    .ID_usesRs2_I       (ID_usesRs2_I),
    .EX_rdAddr_I        (EX_rdAddr_I),
    .EX_memReadEnable_I (EX_memReadEnable_I),
    .EX_branchTaken_I   (EX_branchTaken_I),
    .memBusy_I          (memBusy_I),
    .counterClear_I     (counterClear_I),
    .pcWriteEn_O        (pcWriteEn_O),
    .IF_ID_enable_O     (IF_ID_enable_O),
    .IF_ID_flush_O      (IF_ID_flush_O),
    .ID_EX_enable_O     (ID_EX_enable_O),
    .ID_EX_bubble_O     (ID_EX_bubble_O),
    .state_O            (state_O),
    .stallCount_O       (stallCount_O),
    .flushCount_O       (flushCount_O),
    .memTimeout_O       (memTimeout_O)
  );

  typedef struct {
    bit       rst_n;
    bit       busy;
    bit       br;
    bit       ld;
    bit       u1;
    bit       u2;
    bit       clr;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
  } stim_t;

  int total = 0;
  int bad   = 0;

  // Model state: last action, counters and busy streak as plain integers.
  int m_action  = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  int m_busyrun = 0;
  bit m_timeout = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.busy = 1'b0; s.br = 1'b0; s.ld = 1'b0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.clr = 1'b0;
    s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0;
    return s;
  endfunction

  // One cycle: drive at the falling edge, check everything 1 ns later,
  // advance the model, then let the rising edge happen.
  task automatic step(input stim_t s);
    bit hazard;
    int action;
    @(negedge clk_I);
    reset_I            = s.rst_n;
    memBusy_I          = s.busy;
    EX_branchTaken_I   = s.br;
    EX_memReadEnable_I = s.ld;
    EX_rdAddr_I        = s.rd;
    ID_rs1Addr_I       = s.rs1;
    ID_rs2Addr_I       = s.rs2;
    ID_usesRs1_I       = s.u1;
    ID_usesRs2_I       = s.u2;
    counterClear_I     = s.clr;
    #1;
    if (!s.rst_n) begin
      m_action = 0; m_stall = 0; m_flush = 0; m_busyrun = 0; m_timeout = 1'b0;
    end
    hazard = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    // action: -1 reset, 0 normal, 1 stall, 2 flush, 3 freeze
    if (!s.rst_n)    action = -1;
    else if (s.busy) action = 3;
    else if (s.br)   action = 2;
    else if (hazard) action = 1;
    else             action = 0;

    chk("pcWriteEn",    int'(pcWriteEn_O),    int'(action == 0 || action == 2));
    chk("IF_ID_enable", int'(IF_ID_enable_O), int'(action == 0 || action == 2));
    chk("IF_ID_flush",  int'(IF_ID_flush_O),  int'(action == 2));
    chk("ID_EX_enable", int'(ID_EX_enable_O), int'(action >= 0 && action <= 2));
    chk("ID_EX_bubble", int'(ID_EX_bubble_O), int'(action == 1 || action == 2));
    chk("state",        int'(state_O),        m_action);
    chk("stallCount",   int'(stallCount_O),   m_stall);
    chk("flushCount",   int'(flushCount_O),   m_flush);
    chk("memTimeout",   int'(memTimeout_O),   int'(m_timeout));

    if (s.rst_n) begin
      m_action = action;
      if (s.clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (action == 1 || action == 3) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (action == 2)                m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
      end
      if (s.busy && m_busyrun == 255) m_timeout = 1'b1;
      m_busyrun = s.busy ? ((m_busyrun + 1 > 255) ? 255 : m_busyrun + 1) : 0;
    end
    @(posedge clk_I);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    step(s);
  endtask

  initial begin
    stim_t s;
    stim_t lu;
    reset_I = 1'b0;
    {memBusy_I, EX_branchTaken_I, EX_memReadEnable_I, ID_usesRs1_I, ID_usesRs2_I, counterClear_I} = '0;
    {EX_rdAddr_I, ID_rs1Addr_I, ID_rs2Addr_I} = '0;

    do_reset();
    #1 chk("lit_reset_state", int'(state_O), 0);

    // Load-use on rs2
    lu = idle();
    lu.ld = 1'b1; lu.rd = 5'd5; lu.rs2 = 5'd5; lu.u2 = 1'b1;
    step(lu);
    #1;
    chk("lit_lu_state", int'(state_O), 1);
    chk("lit_lu_stall", int'(stallCount_O), 1);

    // x0 destination and unused source produce no stall
    s = idle(); s.ld = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    step(s);
    s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b0;
    step(s);
    #1 chk("lit_nostall_state", int'(state_O), 0);

    // Branch together with load-use resolves as a flush
    s = lu; s.br = 1'b1;
    step(s);
    #1;
    chk("lit_brlu_flush", int'(flushCount_O), 1);
    chk("lit_brlu_stall", int'(stallCount_O), 1);
    chk("lit_brlu_state", int'(state_O), 2);

    // Reset in the middle of a stall, then normal evaluation afterwards
    step(lu);
    do_reset();
    step(idle());
    #1 chk("lit_post_reset_state", int'(state_O), 0);

    // Memory busy for 3 cycles during a branch, then the flush
    s = idle(); s.br = 1'b1; s.busy = 1'b1;
    repeat (3) step(s);
    #1 chk("lit_freeze_stall", int'(stallCount_O), 3);
    s.busy = 1'b0;
    step(s);
    #1;
    chk("lit_freeze_flush", int'(flushCount_O), 1);
    chk("lit_freeze_stall2", int'(stallCount_O), 3);

    // Memory timeout
    s = idle(); s.busy = 1'b1;
    repeat (257) step(s);
    #1 chk("lit_timeout_set", int'(memTimeout_O), 1);
    step(idle());
    s = idle(); s.clr = 1'b1;
    step(s);
    #1;
    chk("lit_timeout_after_clr", int'(memTimeout_O), 1);
    chk("lit_clr_stall", int'(stallCount_O), 0);
    do_reset();
    #1 chk("lit_timeout_reset", int'(memTimeout_O), 0);

    // Stall counter saturation
    repeat (65540) step(lu);
    #1 chk("lit_sat_stall", int'(stallCount_O), 65535);
    s = lu; s.clr = 1'b1;
    step(s);
    #1 chk("lit_sat_clear", int'(stallCount_O), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.busy  = ($urandom_range(0, 7) == 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.ld    = $urandom_range(0, 1);
      s.u1    = $urandom_range(0, 1);
      s.u2    = $urandom_range(0, 1);
      s.clr   = ($urandom_range(0, 49) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      step(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
